// File: rtl/lifo_stack_pkg.sv
// Shared types for the register-based LIFO: per-cycle operation and per-cell next-value select.
package lifo_stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_ABOVE,
    SEL_BELOW,
    SEL_DATA
  } cell_sel_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPLACE;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lifo_cell.sv
// One stack stage: registered mux of hold / neighbour above / neighbour below / new data.
module lifo_cell
  import lifo_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cell_sel_e        sel,
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] below,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_ABOVE: q <= above;
        SEL_BELOW: q <= below;
        SEL_DATA:  q <= data;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/lifo_stack.sv
// Register-based hardware stack with TOS/NOS visible combinationally; push, pop and replace per cycle.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_s0,
  output logic [WIDTH-1:0] o_s1,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  stack_op_e        op;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] e   [DEPTH];
  // Zero-padded view of the entries so every cell has an above and below neighbour;
  // a pop shifts zero into the deepest slot, keeping empty slots at 0.
  logic [WIDTH-1:0] ext [DEPTH+2];

  assign op = decode_op(i_push, i_pop);

  assign ext[0]       = '0;
  assign ext[DEPTH+1] = '0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cell
    cell_sel_e sel;

    assign ext[k+1] = e[k];

    always_comb begin
      sel = SEL_HOLD;
      case (op)
        OP_PUSH:    sel = (k == 0) ? SEL_DATA : SEL_ABOVE;
        OP_POP:     sel = SEL_BELOW;
        OP_REPLACE: sel = (k == 0) ? SEL_DATA : SEL_HOLD;
        default:    sel = SEL_HOLD;
      endcase
    end

    lifo_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .sel   (sel),
      .above (ext[k]),
      .below (ext[k+2]),
      .data  (i_data),
      .q     (e[k])
    );
  end

  // Replace on an empty stack behaves as a push so the count tracks the new TOS.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count <= '0;
    end else begin
      case (op)
        OP_PUSH:    if (count != FULL_CNT) count <= count + ONE_CNT;
        OP_POP:     if (count != '0) count <= count - ONE_CNT;
        OP_REPLACE: if (count == '0) count <= ONE_CNT;
        default:    count <= count;
      endcase
    end
  end

  assign o_s0    = e[0];
  assign o_s1    = e[1];
  assign o_empty = (count == '0);
  assign o_full  = (count == FULL_CNT);

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: driver queues expected outputs from a queue-based stack model.
module tb_lifo_stack;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 12;

  typedef struct {
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic             empty;
    logic             full;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] data;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic             empty;
  logic             full;

  int unsigned tests  = 0;
  int unsigned errors = 0;

  exp_t             exp_q [$];
  logic [WIDTH-1:0] model [$];

  lifo_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (data),
    .i_push  (push),
    .i_pop   (pop),
    .o_s0    (s0),
    .o_s1    (s1),
    .o_empty (empty),
    .o_full  (full)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_view();
    exp_t v;
    v.s0    = (model.size() > 0) ? model[0] : '0;
    v.s1    = (model.size() > 1) ? model[1] : '0;
    v.empty = (model.size() == 0);
    v.full  = (model.size() == DEPTH);
    return v;
  endfunction

  // Called just after a rising edge: drives one op, records the pre-op view, then applies the op.
  task automatic do_op(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic rst);
    rst_n = ~rst;
    push  = p;
    pop   = q;
    data  = d;
    exp_q.push_back(model_view());
    if (rst) begin
      model.delete();
    end else if (p && q) begin
      if (model.size() == 0) model.push_front(d);
      else model[0] = d;
    end else if (p) begin
      model.push_front(d);
      if (model.size() > DEPTH) void'(model.pop_back());
    end else if (q) begin
      if (model.size() > 0) void'(model.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("s0", s0, e.s0);
      check("s1", s1, e.s1);
      check("empty", WIDTH'(empty), WIDTH'(e.empty));
      check("full", WIDTH'(full), WIDTH'(e.full));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bias;
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Directed scenarios
    do_op(1, 0, 13, 0);
    do_op(1, 0, 21, 0);
    do_op(0, 1, 0, 0);
    do_op(1, 1, 34, 0);
    do_op(1, 0, 55, 0);
    do_op(1, 0, 89, 0);
    do_op(0, 1, 0, 0);
    do_op(0, 1, 0, 0);
    do_op(0, 1, 0, 0);
    do_op(0, 0, 0, 0);
    for (int i = 1; i <= DEPTH + 1; i++) do_op(1, 0, WIDTH'(i), 0);
    for (int i = 0; i < DEPTH; i++) do_op(0, 1, 0, 0);
    do_op(0, 1, 0, 0);
    do_op(1, 1, 7, 0);
    do_op(0, 1, 0, 0);
    do_op(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_op(1, 0, WIDTH'(100 + i), 0);
    do_op(1, 0, 500, 1);
    do_op(1, 0, 501, 1);
    do_op(0, 0, 0, 0);

    // Random phases alternate push-heavy and pop-heavy to reach both boundaries
    bias = 50;
    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      logic p, q;
      if (i % 100 == 0) bias = $urandom_range(15, 85);
      r = $urandom_range(0, 99);
      p = ($urandom_range(0, 99) < bias);
      q = ($urandom_range(0, 99) >= bias);
      if ($urandom_range(0, 9) == 0) begin
        p = 1'b1;
        q = 1'b1;
      end
      do_op(p, q, WIDTH'($urandom), (r < 2));
    end

    do_op(0, 0, 0, 0);
    do_op(0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
